// File: rtl/sap_pkg.sv
// Shared constants and state type for the 16-source bus multiplexer.
// Provides NUM_SRC, SEL_W, default DATA_W and the EMPTY/FULL output state.
package sap_pkg;

    localparam int NUM_SRC    = 16;
    localparam int SEL_W      = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_16.sv
// Winner selection for 16 requesters: one-hot grant vector and its index.
// Ports: req (16 requests), ptr (search start, only with ROUND_ROBIN_EN),
// onehot/idx (winner), any (at least one request). Fixed priority otherwise.
module rr_arbiter_16
    import sap_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
`ifdef ROUND_ROBIN_EN
    input  logic [SEL_W-1:0]   ptr,
`endif
    output logic [NUM_SRC-1:0] onehot,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = |req;
        // Scan from lowest to highest priority so the last hit wins.
`ifdef ROUND_ROBIN_EN
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) begin
                idx = ptr + SEL_W'(k);
            end
        end
`else
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[k]) begin
                idx = SEL_W'(k);
            end
        end
`endif
        if (any) begin
            onehot = NUM_SRC'(1) << idx;
        end
    end

endmodule

// File: rtl/bus_mux_16line_8bit.sv
// 16-source to one registered output bus multiplexer with valid/ready output.
// Ports: clk, rst_n (async low), in0..in15, req, gnt (comb one-hot),
// out/out_sel/out_valid (registered), out_ready. Option: ROUND_ROBIN_EN.
module bus_mux_16line_8bit
    import sap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  in0,
    input  logic [DATA_W-1:0]  in1,
    input  logic [DATA_W-1:0]  in2,
    input  logic [DATA_W-1:0]  in3,
    input  logic [DATA_W-1:0]  in4,
    input  logic [DATA_W-1:0]  in5,
    input  logic [DATA_W-1:0]  in6,
    input  logic [DATA_W-1:0]  in7,
    input  logic [DATA_W-1:0]  in8,
    input  logic [DATA_W-1:0]  in9,
    input  logic [DATA_W-1:0]  in10,
    input  logic [DATA_W-1:0]  in11,
    input  logic [DATA_W-1:0]  in12,
    input  logic [DATA_W-1:0]  in13,
    input  logic [DATA_W-1:0]  in14,
    input  logic [DATA_W-1:0]  in15,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] gnt,
    output logic [DATA_W-1:0]  out,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [DATA_W-1:0]  src [NUM_SRC];
    logic [NUM_SRC-1:0] win_oh;
    logic [SEL_W-1:0]   win_idx;
    logic               win_any;
    logic               accept;
    state_t             state;
    state_t             state_nx;

    assign src[0]  = in0;
    assign src[1]  = in1;
    assign src[2]  = in2;
    assign src[3]  = in3;
    assign src[4]  = in4;
    assign src[5]  = in5;
    assign src[6]  = in6;
    assign src[7]  = in7;
    assign src[8]  = in8;
    assign src[9]  = in9;
    assign src[10] = in10;
    assign src[11] = in11;
    assign src[12] = in12;
    assign src[13] = in13;
    assign src[14] = in14;
    assign src[15] = in15;

`ifdef ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr;

    rr_arbiter_16 u_arb (
        .req    (req),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    // Index arithmetic is SEL_W wide, so 15 + 1 wraps to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= win_idx + SEL_W'(1);
        end
    end
`else
    rr_arbiter_16 u_arb (
        .req    (req),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );
`endif

    assign out_valid = (state == FULL);

    always_comb begin
        state_nx = state;
        accept   = win_any && (!out_valid || out_ready);
        gnt      = '0;
        // Grant is suppressed while reset is held low.
        if (accept && rst_n) begin
            gnt = win_oh;
        end
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx = FULL;
                end
            end
            FULL: begin
                if (out_ready && !accept) begin
                    state_nx = EMPTY;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= '0;
            out_sel <= '0;
        end else if (accept) begin
            out     <= src[win_idx];
            out_sel <= win_idx;
        end
    end

endmodule

// File: tb/tb_bus_mux_16line_8bit.sv
// Self-checking bench for bus_mux_16line_8bit: directed scenarios plus
// randomized traffic against a behavioural model of the valid/ready mux.
module tb_bus_mux_16line_8bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din [16];
    logic [15:0] req;
    logic [15:0] gnt;
    logic [7:0]  out;
    logic [3:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    bit         mv;
    logic [7:0] mout;
    int         msel;
    int         mptr;
    logic [15:0] gnt_seen;

    always #5 clk = ~clk;

    bus_mux_16line_8bit #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (din[0]),
        .in1       (din[1]),
        .in2       (din[2]),
        .in3       (din[3]),
        .in4       (din[4]),
        .in5       (din[5]),
        .in6       (din[6]),
        .in7       (din[7]),
        .in8       (din[8]),
        .in9       (din[9]),
        .in10      (din[10]),
        .in11      (din[11]),
        .in12      (din[12]),
        .in13      (din[13]),
        .in14      (din[14]),
        .in15      (din[15]),
        .req       (req),
        .gnt       (gnt),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Who should win given the request word and the model's pointer.
    function automatic int winner(input logic [15:0] r, input int p);
        winner = -1;
`ifdef ROUND_ROBIN_EN
        for (int k = 15; k >= 0; k--) begin
            if (r[(p + k) % 16]) winner = (p + k) % 16;
        end
`else
        for (int k = 15; k >= 0; k--) begin
            if (r[k]) winner = k;
        end
`endif
    endfunction

    task automatic model_reset();
        mv   = 1'b0;
        mout = 8'h00;
        msel = 0;
        mptr = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, mv});
        chk({tag, "_out"}, {24'd0, out}, {24'd0, mout});
        chk({tag, "_sel"}, {28'd0, out_sel}, msel);
    endtask

    // One clock: check gnt against the model, advance model, check outputs.
    task automatic cycle(input string tag);
        int w;
        logic [15:0] eg;
        bit acc;
        #1;
        w   = winner(req, mptr);
        acc = (w >= 0) && (!mv || out_ready);
        eg  = acc ? (16'h1 << w) : 16'h0;
        gnt_seen = gnt;
        chk({tag, "_gnt"}, {16'd0, gnt}, {16'd0, eg});
        if (acc) begin
            mv   = 1'b1;
            mout = din[w];
            msel = w;
            mptr = (w + 1) % 16;
        end else if (mv && out_ready) begin
            mv = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_sel", {28'd0, out_sel}, 32'd0);
        chk("rst_gnt", {16'd0, gnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_sel;
        rst_n     = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) din[i] = 8'h00;
        model_reset();
        #2;
        do_reset();

        // Single request from source 5.
        din[5]    = 8'h07;
        req       = 16'h0020;
        out_ready = 1'b1;
        cycle("r28");
        chk("r28_gnt_lit", {16'd0, gnt_seen}, 32'h20);
        chk("r28_out_lit", {24'd0, out}, 32'h07);
        chk("r28_sel_lit", {28'd0, out_sel}, 32'd5);
        chk("r28_vld_lit", {31'd0, out_valid}, 32'd1);

        // Drain with no requests, then wiggle out_ready while empty.
        req = '0;
        cycle("r31");
        chk("r31_vld_lit", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            out_ready = i[0];
            cycle("r31t");
            chk("r31t_vld_lit", {31'd0, out_valid}, 32'd0);
            chk("r31t_sel_lit", {28'd0, out_sel}, 32'd5);
        end

        // All sources requesting from a fresh pointer.
        do_reset();
        for (int i = 0; i < 16; i++) din[i] = 8'(i);
        req       = 16'hFFFF;
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            cycle("r29");
`ifdef ROUND_ROBIN_EN
            exp_sel = k % 16;
`else
            exp_sel = 0;
`endif
            chk("r29_sel_lit", {28'd0, out_sel}, exp_sel);
            chk("r29_onehot", {31'd0, $onehot(gnt_seen)}, 32'd1);
        end

        // Stall with a full register, then release.
        din[3] = 8'hA3;
        din[8] = 8'h5C;
        req    = 16'h0008;
        cycle("r30a");
        chk("r30a_sel_lit", {28'd0, out_sel}, 32'd3);
        req       = 16'h0100;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle("r30s");
            chk("r30s_gnt_lit", {16'd0, gnt_seen}, 32'd0);
            chk("r30s_sel_lit", {28'd0, out_sel}, 32'd3);
            chk("r30s_out_lit", {24'd0, out}, 32'hA3);
        end
        out_ready = 1'b1;
        cycle("r30r");
        chk("r30r_gnt_lit", {16'd0, gnt_seen}, 32'h100);
        chk("r30r_sel_lit", {28'd0, out_sel}, 32'd8);

        // Reset arriving mid-cycle while full.
        din[9] = 8'h99;
        req    = 16'h0200;
        cycle("r32a");
        chk("r32a_sel_lit", {28'd0, out_sel}, 32'd9);
        #2;
        do_reset();
        din[0] = 8'h11;
        req    = 16'h0201;
        cycle("r32b");
        chk("r32b_sel_lit", {28'd0, out_sel}, 32'd0);
        chk("r32b_out_lit", {24'd0, out}, 32'h11);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 16; i++) din[i] = 8'($urandom);
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = 16'h1 << $urandom_range(0, 15);
                2: req = 16'($urandom) & 16'($urandom);
                default: req = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
